// File: rtl/vector_shift_left_byte.sv
// Per-lane logical left shift of vra bytes by the low 3 bits of the matching vrb byte.
// Single register stage: one result per accepted operation, exactly one cycle later.
module vector_shift_left_byte #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [8*LANES-1:0] vra,
    input  logic [8*LANES-1:0] vrb,
    output logic               out_valid,
    output logic [8*LANES-1:0] vrt
);

    logic [8*LANES-1:0] res_next;
    logic [8*LANES-1:0] vrt_reg;
    logic               out_valid_reg;

    // Lanes are fully independent; vrb bits [7:3] never reach the shifter,
    // so an amount of 8 wraps to 0.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [2:0] sh;
            logic [7:0] src;

            assign sh  = vrb[8*gi +: 3];
            assign src = vra[8*gi +: 8];
            assign res_next[8*gi +: 8] = src << sh;
        end
    endgenerate

    // vrt keeps its last result when idle; out_valid is a one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vrt_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                vrt_reg <= res_next;
            end
        end
    end

    assign vrt       = vrt_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_vector_shift_left_byte.sv
// Self-checking bench: directed vectors, reset behaviour and random traffic
// compared against an arithmetic per-lane reference model.
module tb_vector_shift_left_byte;

    localparam int LANES = 4;
    localparam int W     = 8 * LANES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] vra;
    logic [W-1:0] vrb;
    logic         out_valid;
    logic [W-1:0] vrt;

    int unsigned  errors;
    int unsigned  checks;
    logic [W-1:0] exp_vrt;
    logic         exp_valid;

    vector_shift_left_byte #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .vra       (vra),
        .vrb       (vrb),
        .out_valid (out_valid),
        .vrt       (vrt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: multiply by 2**(amount mod 8) and keep the low byte, lane by lane.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned acc;
        acc = 0;
        for (int i = 0; i < LANES; i++) begin
            int unsigned byte_a, amt, r;
            byte_a = (int'(a) >> (8 * i)) & 255;
            amt    = ((int'(b) >> (8 * i)) & 255) % 8;
            r      = (byte_a * (1 << amt)) % 256;
            acc    = acc | (r << (8 * i));
        end
        return W'(acc);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus and check the registered outputs after the edge.
    task automatic do_op(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v;
        vra      = a;
        vrb      = b;
        @(posedge clk);
        #1;
        if (v) exp_vrt = ref_shift(a, b);
        exp_valid = v;
        $display("op v=%0d vra=0x%08h vrb=0x%08h -> vrt=0x%08h out_valid=%0d",
                 v, a, b, vrt, out_valid);
        check("out_valid", W'(out_valid), W'(exp_valid));
        check("vrt", vrt, exp_vrt);
    endtask

    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] lit);
        do_op(1'b1, a, b);
        check("vrt_literal", vrt, lit);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_vrt   = '0;
        exp_valid = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        vra       = 32'hFFFF_FFFF;
        vrb       = 32'h0101_0101;

        repeat (2) @(posedge clk);
        #1;
        check("reset_vrt", vrt, '0);
        check("reset_valid", W'(out_valid), '0);
        rst_n = 1'b1;

        directed(32'h0101_0101, 32'h0102_0304, 32'h0204_0810);
        directed(32'hFFFF_FFFF, 32'h0807_0605, 32'hFF80_C0E0);
        directed(32'h0F0F_0F0F, 32'h0102_0408, 32'h1E3C_F00F);
        directed(32'hA5A5_A5A5, 32'hF8F9_FAFB, 32'hA54A_9428);

        // Single pulse, then idle: out_valid must drop while vrt holds.
        do_op(1'b1, 32'h1234_5678, 32'h0001_0203);
        for (int i = 0; i < 3; i++) do_op(1'b0, $urandom, $urandom);

        // Reset asserted between edges while an operation is being presented.
        do_op(1'b1, 32'hDEAD_BEEF, 32'h0304_0506);
        in_valid = 1'b1;
        vra      = 32'hCAFE_F00D;
        vrb      = 32'h0102_0304;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted -> vrt=0x%08h out_valid=%0d", vrt, out_valid);
        check("async_rst_vrt", vrt, '0);
        check("async_rst_valid", W'(out_valid), '0);
        @(posedge clk);
        #1;
        check("held_rst_vrt", vrt, '0);
        check("held_rst_valid", W'(out_valid), '0);
        exp_vrt   = '0;
        exp_valid = 1'b0;
        rst_n     = 1'b1;
        do_op(1'b1, 32'h8040_2010, 32'h0101_0101);
        check("post_rst_literal", vrt, 32'h0080_4020);

        // Random traffic with frequent back-to-back operations.
        for (int i = 0; i < 10000; i++) begin
            do_op(($urandom_range(0, 3) != 0), $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
